// File: rtl/p88_load_sequencer_pkg.sv
// p88_load_sequencer_pkg: shared states, P88 command bytes and address helpers
package p88_load_sequencer_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_HDR8, ST_DATA, ST_ENT4, ST_VEC, ST_WRITE} state_e;
  typedef enum logic [1:0] {W_IDLE, W_GNT, W_DONE} wr_phase_e;
  localparam logic [7:0] P88_CMD_SECTION = 8'hC8;
  localparam logic [7:0] P88_CMD_ENTRY   = 8'hCA;
  localparam logic [7:0] FAR_JMP_OPCODE  = 8'hEA;
  localparam int HDR_BYTES = 8;
  localparam int ENT_BYTES = 4;
  localparam int VEC_BYTES = 5;
  function automatic logic [31:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {12'd0, seg, 4'd0} + {16'd0, off};
  endfunction
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v + {7'd0, v != 8'hFF};
  endfunction
endpackage

// File: rtl/p88_load_sequencer_if.sv
// p88_load_sequencer_if: ioctl download stream plus memory write port
interface p88_load_sequencer_if #(parameter int ADDR_W = 20) ();
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  modport master (input ioctl_download, ioctl_wr, ioctl_dout, mem_gnt,
                  output ioctl_wait, mem_req, mem_sel, mem_addr, mem_din, mem_we);
  modport slave  (output ioctl_download, ioctl_wr, ioctl_dout, mem_gnt,
                  input ioctl_wait, mem_req, mem_sel, mem_addr, mem_din, mem_we);
endinterface

// File: rtl/p88_mem_writer.sv
// p88_mem_writer: one-byte req/gnt/we handshake with grant timeout and addr/len bookkeeping
module p88_mem_writer
  import p88_load_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              abort,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_len,
  input  logic              load_sel,
  input  logic              start,
  input  logic [7:0]        data,
  input  logic              gnt,
  output logic              req,
  output logic              we,
  output logic              sel,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        din,
  output logic              done,
  output logic              last,
  output logic              timeout
);
  localparam int CW = $clog2(GNT_TIMEOUT + 1);
  wr_phase_e     phase;
  logic [15:0]   len;
  logic [CW-1:0] wait_cnt;
  // strobe is gated by the live grant so it can never fire without it
  assign we = (phase == W_GNT) & gnt;
  // handshake phases; a timed-out byte is retired exactly like a written one
  always_ff @(posedge clk_sys)
    if (reset || abort) begin
      phase    <= W_IDLE;
      req      <= 1'b0;
      sel      <= 1'b0;
      addr     <= '0;
      din      <= '0;
      len      <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
      last     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (load) begin
        addr <= load_addr;
        len  <= load_len;
        sel  <= load_sel;
      end
      if (phase == W_IDLE && start) begin
        phase    <= W_GNT;
        req      <= 1'b1;
        din      <= data;
        wait_cnt <= '0;
      end
      if (phase == W_GNT) begin
        if (gnt) phase <= W_DONE;
        else if (wait_cnt == CW'(GNT_TIMEOUT - 1)) begin
          phase   <= W_DONE;
          timeout <= 1'b1;
        end else wait_cnt <= wait_cnt + CW'(1);
      end
      if (phase == W_DONE) begin
        phase <= W_IDLE;
        req   <= 1'b0;
        addr  <= addr + ADDR_W'(1);
        len   <= len - 16'd1;
        done  <= 1'b1;
        last  <= len == 16'd1;
      end
    end
endmodule

// File: rtl/p88_load_sequencer.sv
// p88_load_sequencer: parses a P88 download into DRAM section writes and a ROM boot vector
module p88_load_sequencer
  import p88_load_sequencer_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int ROM_VEC_BASE = 0,
  parameter int GNT_TIMEOUT  = 255
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  p88_load_sequencer_if.master bus,
  output logic                 hold_reset,
  output logic                 load_error,
  output logic [7:0]           section_cnt
);
  state_e      state;
  logic        dl_q, rise, fall, take, load, start, done, last, timeout;
  logic [15:0] seg, off, hdr_len;
  logic [7:0]  len_lo, vec_byte;
  logic [2:0]  idx;
  assign rise     = bus.ioctl_download & ~dl_q;
  assign fall     = ~bus.ioctl_download & dl_q;
  assign take     = bus.ioctl_wr & ~bus.ioctl_wait;
  assign hdr_len  = {bus.ioctl_dout, len_lo};
  assign load     = take && ((state == ST_HDR8 && idx == 3'(HDR_BYTES - 1)) ||
                             (state == ST_ENT4 && idx == 3'(ENT_BYTES - 1)));
  assign start    = (state == ST_DATA && take) || state == ST_VEC;
  assign vec_byte = idx == 3'd0 ? FAR_JMP_OPCODE : idx == 3'd1 ? off[7:0] :
                    idx == 3'd2 ? off[15:8] : idx == 3'd3 ? seg[7:0] : seg[15:8];
  p88_mem_writer #(.ADDR_W(ADDR_W), .GNT_TIMEOUT(GNT_TIMEOUT)) u_writer (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .abort    (fall),
    .load     (load),
    .load_addr(state == ST_ENT4 ? ADDR_W'(ROM_VEC_BASE) : ADDR_W'(phys_addr(seg, off))),
    .load_len (state == ST_ENT4 ? 16'(VEC_BYTES) : hdr_len),
    .load_sel (state == ST_ENT4),
    .start    (start),
    .data     (state == ST_VEC ? vec_byte : bus.ioctl_dout),
    .gnt      (bus.mem_gnt),
    .req      (bus.mem_req),
    .we       (bus.mem_we),
    .sel      (bus.mem_sel),
    .addr     (bus.mem_addr),
    .din      (bus.mem_din),
    .done     (done),
    .last     (last),
    .timeout  (timeout)
  );
  // parser FSM: download edges first, then command/header/data/vector sequencing
  always_ff @(posedge clk_sys)
    if (reset) begin
      state          <= ST_IDLE;
      dl_q           <= 1'b0;
      hold_reset     <= 1'b0;
      load_error     <= 1'b0;
      section_cnt    <= '0;
      bus.ioctl_wait <= 1'b0;
      seg            <= '0;
      off            <= '0;
      len_lo         <= '0;
      idx            <= '0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (fall) begin
        state          <= ST_IDLE;
        hold_reset     <= 1'b0;
        bus.ioctl_wait <= 1'b0;
      end else if (rise) begin
        state       <= ST_CMD;
        hold_reset  <= 1'b1;
        load_error  <= 1'b0;
        section_cnt <= '0;
        idx         <= '0;
      end else begin
        if (timeout) load_error <= 1'b1;
        if (take && (state == ST_HDR8 || state == ST_ENT4)) begin
          idx <= idx + 3'd1;
          if (idx == 3'd0) seg[7:0]  <= bus.ioctl_dout;
          if (idx == 3'd1) seg[15:8] <= bus.ioctl_dout;
          if (idx == 3'd2) off[7:0]  <= bus.ioctl_dout;
          if (idx == 3'd3) off[15:8] <= bus.ioctl_dout;
          if (idx == 3'd6) len_lo    <= bus.ioctl_dout;
        end
        case (state)
          ST_CMD: if (take) begin
            idx   <= '0;
            state <= bus.ioctl_dout == P88_CMD_SECTION ? ST_HDR8 :
                     bus.ioctl_dout == P88_CMD_ENTRY ? ST_ENT4 : ST_CMD;
            if (bus.ioctl_dout != P88_CMD_SECTION && bus.ioctl_dout != P88_CMD_ENTRY) load_error <= 1'b1;
          end
          ST_HDR8: if (load) begin
            state <= hdr_len == 16'd0 ? ST_CMD : ST_DATA;
            if (hdr_len == 16'd0) section_cnt <= sat_inc(section_cnt);
          end
          ST_ENT4: if (load) begin
            state          <= ST_VEC;
            idx            <= '0;
            bus.ioctl_wait <= 1'b1;
          end
          ST_DATA: if (take) begin
            state          <= ST_WRITE;
            bus.ioctl_wait <= 1'b1;
          end
          ST_VEC: state <= ST_WRITE;
          ST_WRITE: if (done) begin
            if (bus.mem_sel && !last) begin
              state <= ST_VEC;
              idx   <= idx + 3'd1;
            end else begin
              bus.ioctl_wait <= 1'b0;
              state          <= last ? ST_CMD : ST_DATA;
              if (last && !bus.mem_sel) section_cnt <= sat_inc(section_cnt);
            end
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_p88_load_sequencer.sv
// tb_p88_load_sequencer: directed P88 download scenarios with assertion-based checks
module tb_p88_load_sequencer;
  logic clk_sys = 1'b0;
  logic reset;
  logic hold_reset, load_error;
  logic [7:0] section_cnt;
  int n_assert = 0;
  int n_fail = 0;
  logic [19:0] wa[$];
  logic [7:0]  wd[$];
  logic        ws[$];
  logic [7:0]  sq[$];
  int bad_we = 0, unstable = 0, wait_run = 0, max_run = 0;
  logic req_q = 1'b0;
  logic [19:0] addr_q;
  logic [7:0]  din_q;
  logic [7:0]  vec_exp [5] = '{8'hEA, 8'h34, 8'h12, 8'h00, 8'hF0};
  logic [7:0]  sec_exp [3] = '{8'hAA, 8'hBB, 8'hCC};
  logic [19:0] a0;
  logic [7:0]  d0;
  int bad;

  p88_load_sequencer_if #(.ADDR_W(20)) bus ();
  p88_load_sequencer dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .hold_reset (hold_reset),
    .load_error (load_error),
    .section_cnt(section_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_din);
      ws.push_back(bus.mem_sel);
      if (!bus.mem_gnt) bad_we++;
    end
    if (bus.mem_req && req_q && (bus.mem_addr !== addr_q || bus.mem_din !== din_q)) unstable++;
    req_q  = bus.mem_req;
    addr_q = bus.mem_addr;
    din_q  = bus.mem_din;
    wait_run = bus.ioctl_wait ? wait_run + 1 : 0;
    if (wait_run > max_run) max_run = wait_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.ioctl_wait && n < 400) begin tick(1); n++; end
    check("send_stall_bound", 32'(n < 400), 1);
    bus.ioctl_wr = 1'b1;
    bus.ioctl_dout = b;
    tick(1);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic send_all();
    foreach (sq[i]) send(sq[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.ioctl_wait && n < 400) begin tick(1); n++; end
    check("drain_bound", 32'(n < 400), 1);
    tick(1);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); ws.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_dout = 8'h00;
    bus.mem_gnt = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_hold", hold_reset, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_wait", bus.ioctl_wait, 0);
    check("rst_err", load_error, 0);
    check("rst_cnt", section_cnt, 0);
    check("rst_addr", bus.mem_addr, 0);
    // section: seg 0x0010, off 0x0004, len 3
    bus.ioctl_download = 1'b1;
    tick(1);
    check("rise_hold", hold_reset, 1);
    clear_log();
    max_run = 0;
    sq = '{8'hC8, 8'h10, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send_all();
    wait_idle();
    check("sec_nwr", wa.size(), 3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      check("sec_addr", wa[i], 20'h00104 + i);
      check("sec_data", wd[i], sec_exp[i]);
      check("sec_sel", ws[i], 0);
    end
    check("sec_cnt", section_cnt, 1);
    check("sec_wait_run", max_run, 3);
    // entry vector: seg 0xF000, off 0x1234
    clear_log();
    sq = '{8'hCA, 8'h00, 8'hF0, 8'h34, 8'h12};
    send_all();
    wait_idle();
    check("vec_nwr", wa.size(), 5);
    for (int i = 0; i < 5 && i < wa.size(); i++) begin
      check("vec_addr", wa[i], i);
      check("vec_data", wd[i], vec_exp[i]);
      check("vec_sel", ws[i], 1);
    end
    check("vec_hold", hold_reset, 1);
    check("vec_err", load_error, 0);
    bus.ioctl_download = 1'b0;
    tick(1);
    check("fall_hold", hold_reset, 0);
    check("fall_sel", bus.mem_sel, 0);
    // 20-bit wrap: seg 0xFFFF, off 0x0020, len 2
    bus.ioctl_download = 1'b1;
    tick(1);
    clear_log();
    sq = '{8'hC8, 8'hFF, 8'hFF, 8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22};
    send_all();
    wait_idle();
    check("wrap_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      check("wrap_a0", wa[0], 20'h00010);
      check("wrap_a1", wa[1], 20'h00011);
      check("wrap_d1", wd[1], 8'h22);
    end
    // grant withheld for 10 cycles, stray byte during stall
    clear_log();
    bus.mem_gnt = 1'b0;
    sq = '{8'hC8, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00};
    send_all();
    send(8'h5A);
    a0 = bus.mem_addr;
    d0 = bus.mem_din;
    check("stall_addr", a0, 20'h00200);
    check("stall_din", d0, 8'h5A);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin bus.ioctl_wr = 1'b1; bus.ioctl_dout = 8'h77; end
      tick(1);
      bus.ioctl_wr = 1'b0;
      if (bus.mem_we || !bus.mem_req || !bus.ioctl_wait || bus.mem_addr !== a0 || bus.mem_din !== d0) bad++;
    end
    check("stall_hold", bad, 0);
    check("stall_no_we", wa.size(), 0);
    bus.mem_gnt = 1'b1;
    wait_idle();
    check("stall_nwr", wa.size(), 1);
    if (wa.size() == 1) check("stall_wdata", wd[0], 8'h5A);
    check("stall_err", load_error, 0);
    check("stall_cnt", section_cnt, 2);
    // grant never comes: timeout drops the byte and flags error
    clear_log();
    bus.mem_gnt = 1'b0;
    sq = '{8'hC8, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h66};
    send_all();
    wait_idle();
    check("to_err", load_error, 1);
    check("to_nwr", wa.size(), 0);
    check("to_cnt", section_cnt, 3);
    bus.mem_gnt = 1'b1;
    // new download: bad command, then empty section
    bus.ioctl_download = 1'b0;
    tick(2);
    bus.ioctl_download = 1'b1;
    tick(1);
    check("re_err_clr", load_error, 0);
    check("re_cnt_clr", section_cnt, 0);
    clear_log();
    send(8'h55);
    check("badcmd_err", load_error, 1);
    sq = '{8'hC8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_all();
    tick(2);
    check("len0_cnt", section_cnt, 1);
    check("len0_nwr", wa.size(), 0);
    check("len0_wait", bus.ioctl_wait, 0);
    // abort mid-data: len 5, two bytes written, third pending
    sq = '{8'hC8, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h02};
    send_all();
    wait_idle();
    check("abort_pre_nwr", wa.size(), 2);
    bus.mem_gnt = 1'b0;
    send(8'h03);
    check("abort_pre_req", bus.mem_req, 1);
    bus.ioctl_download = 1'b0;
    tick(1);
    check("abort_req", bus.mem_req, 0);
    check("abort_wait", bus.ioctl_wait, 0);
    check("abort_hold", hold_reset, 0);
    bus.mem_gnt = 1'b1;
    tick(3);
    check("abort_nwr", wa.size(), 2);
    check("abort_addr_idle", bus.mem_addr, 0);
    bus.ioctl_download = 1'b1;
    tick(1);
    check("abort_re_err", load_error, 0);
    check("abort_re_cnt", section_cnt, 0);
    check("we_without_gnt", bad_we, 0);
    check("req_stability", unstable, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
